// File: rtl/mc_control_if.sv
// Purpose: bundles the instruction-field inputs and datapath control outputs of mc_control.
// Latency: n/a (signal bundle only).
// Backpressure: none; the controller is free-running with no handshake.
//
// Members:
//   i_opcode, i_funct, i_zf    -> into the controller (instruction fields, ALU zero flag)
//   o_pc_write .. o_pc_src     -> datapath control strobes and selects
//   o_illegal, o_state         -> illegal-instruction pulse and debug state
// Modports: slave = controller side, master = datapath/testbench side.
interface mc_control_if;
  logic [5:0] i_opcode;
  logic [5:0] i_funct;
  logic       i_zf;

  logic       o_pc_write;
  logic       o_iord;
  logic       o_mem_read;
  logic       o_mem_write;
  logic       o_ir_write;
  logic       o_reg_dst;
  logic       o_mem_to_reg;
  logic       o_reg_write;
  logic       o_alu_src_a;
  logic [1:0] o_alu_src_b;
  logic [3:0] o_alu_control;
  logic [1:0] o_pc_src;
  logic       o_illegal;
  logic [3:0] o_state;

  modport slave (
    input  i_opcode, i_funct, i_zf,
    output o_pc_write, o_iord, o_mem_read, o_mem_write, o_ir_write,
           o_reg_dst, o_mem_to_reg, o_reg_write, o_alu_src_a, o_alu_src_b,
           o_alu_control, o_pc_src, o_illegal, o_state
  );

  modport master (
    output i_opcode, i_funct, i_zf,
    input  o_pc_write, o_iord, o_mem_read, o_mem_write, o_ir_write,
           o_reg_dst, o_mem_to_reg, o_reg_write, o_alu_src_a, o_alu_src_b,
           o_alu_control, o_pc_src, o_illegal, o_state
  );
endinterface

// File: rtl/mc_control.sv
// Purpose: multicycle MIPS-subset control FSM (lw, sw, R-type, beq, j, optional addi).
// Latency: 2-5 cycles per instruction (illegal 2, beq/j 3, sw/R/addi 4, lw 5).
// Backpressure: none; advances every cycle, no stall input.
//
// Ports:
//   i_clk    - clock, all state changes on rising edge
//   i_rst_n  - asynchronous active-low reset, forces FETCH immediately
//   bus      - mc_control_if.slave: opcode/funct/zero-flag in, datapath controls out
// Parameter EN_ADDI: 1 = addi supported, 0 = addi decoded as illegal.
module mc_control #(
  parameter bit EN_ADDI = 1'b1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  mc_control_if.slave   bus
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REX    = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_e;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  state_e     state_q, state_d;
  logic [5:0] opcode_q, opcode_d;
  logic [5:0] funct_q, funct_d;
  logic       illegal_q, illegal_d;

  function automatic logic funct_supported(input logic [5:0] f);
    case (f)
      6'b100000, 6'b100010, 6'b100100,
      6'b100101, 6'b100111, 6'b101010: funct_supported = 1'b1;
      default:                         funct_supported = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] funct_to_alu(input logic [5:0] f);
    case (f)
      6'b100010: funct_to_alu = ALU_SUB;
      6'b100100: funct_to_alu = ALU_AND;
      6'b100101: funct_to_alu = ALU_OR;
      6'b100111: funct_to_alu = ALU_NOR;
      6'b101010: funct_to_alu = ALU_SLT;
      default:   funct_to_alu = ALU_ADD;
    endcase
  endfunction

  // Next-state logic. Only DECODE looks at the live instruction fields; it
  // also captures them so later states are immune to IR-input changes.
  always_comb begin
    state_d   = S_FETCH;
    opcode_d  = opcode_q;
    funct_d   = funct_q;
    illegal_d = 1'b0;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        opcode_d = bus.i_opcode;
        funct_d  = bus.i_funct;
        case (bus.i_opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R: begin
            if (funct_supported(bus.i_funct)) state_d = S_REX;
            else                              illegal_d = 1'b1;
          end
          OP_BEQ:  state_d = S_BRANCH;
          OP_J:    state_d = S_JUMP;
          OP_ADDI: begin
            if (EN_ADDI) state_d = S_ADDIEX;
            else         illegal_d = 1'b1;
          end
          default: illegal_d = 1'b1;
        endcase
      end
      // Only lw and sw reach MEMADR, so anything other than lw is a store.
      S_MEMADR: state_d = (opcode_q == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = S_MEMWB;
      S_REX:    state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_FETCH;
      opcode_q  <= 6'd0;
      funct_q   <= 6'd0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      funct_q   <= funct_d;
      illegal_q <= illegal_d;
    end
  end

  // Moore output decode straight off the state register, so an asynchronous
  // reset moves every control to its FETCH value without waiting for a clock.
  // The single exception is BRANCH, where pc_write follows i_zf directly.
  always_comb begin
    bus.o_pc_write    = 1'b0;
    bus.o_iord        = 1'b0;
    bus.o_mem_read    = 1'b0;
    bus.o_mem_write   = 1'b0;
    bus.o_ir_write    = 1'b0;
    bus.o_reg_dst     = 1'b0;
    bus.o_mem_to_reg  = 1'b0;
    bus.o_reg_write   = 1'b0;
    bus.o_alu_src_a   = 1'b0;
    bus.o_alu_src_b   = 2'b00;
    bus.o_alu_control = ALU_ADD;
    bus.o_pc_src      = 2'b00;
    case (state_q)
      S_FETCH: begin
        bus.o_mem_read    = 1'b1;
        bus.o_ir_write    = 1'b1;
        bus.o_pc_write    = 1'b1;
        bus.o_alu_src_b   = 2'b01;
      end
      S_DECODE: bus.o_alu_src_b = 2'b11;
      S_MEMADR, S_ADDIEX: begin
        bus.o_alu_src_a   = 1'b1;
        bus.o_alu_src_b   = 2'b10;
      end
      S_MEMRD: begin
        bus.o_iord        = 1'b1;
        bus.o_mem_read    = 1'b1;
      end
      S_MEMWB: begin
        bus.o_mem_to_reg  = 1'b1;
        bus.o_reg_write   = 1'b1;
      end
      S_MEMWR: begin
        bus.o_iord        = 1'b1;
        bus.o_mem_write   = 1'b1;
      end
      S_REX: begin
        bus.o_alu_src_a   = 1'b1;
        bus.o_alu_control = funct_to_alu(funct_q);
      end
      S_ALUWB: begin
        bus.o_reg_dst     = 1'b1;
        bus.o_reg_write   = 1'b1;
      end
      S_BRANCH: begin
        bus.o_alu_src_a   = 1'b1;
        bus.o_alu_control = ALU_SUB;
        bus.o_pc_src      = 2'b01;
        bus.o_pc_write    = bus.i_zf;
      end
      S_ADDIWB: bus.o_reg_write = 1'b1;
      S_JUMP: begin
        bus.o_pc_src      = 2'b10;
        bus.o_pc_write    = 1'b1;
      end
      // Unused encodings 12-15: everything off, including the ALU opcode.
      default: bus.o_alu_control = 4'b0000;
    endcase
  end

  assign bus.o_illegal = illegal_q;
  assign bus.o_state   = state_q;

endmodule

// File: tb/tb_mc_control.sv
module tb_mc_control;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mc_control_if if0 ();
  mc_control_if if1 ();

  mc_control #(.EN_ADDI(1'b1)) u_dut0 (.i_clk(clk), .i_rst_n(rst_n), .bus(if0));
  mc_control #(.EN_ADDI(1'b0)) u_dut1 (.i_clk(clk), .i_rst_n(rst_n), .bus(if1));

  typedef struct packed {
    logic [3:0] st;
    logic       pc_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       src_a;
    logic [1:0] src_b;
    logic [3:0] alu;
    logic [1:0] pc_src;
    logic       ill;
  } obs_t;

  int checks = 0;
  int errors = 0;
  obs_t exp_q[$];
  int   path_q[$];
  bit   prev_ill = 1'b0;
  int   cyc1 = 0;

  // Supported R-type functs and the ALU code each one selects.
  logic [5:0] valid_funct [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2a};
  logic [3:0] funct_alu   [6] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b1100, 4'b0111};

  function automatic int funct_index(input logic [5:0] f);
    for (int i = 0; i < 6; i++) if (valid_funct[i] == f) return i;
    return -1;
  endfunction

  function automatic obs_t sample0();
    obs_t o;
    o.st = if0.o_state;         o.pc_write = if0.o_pc_write;
    o.iord = if0.o_iord;        o.mem_read = if0.o_mem_read;
    o.mem_write = if0.o_mem_write; o.ir_write = if0.o_ir_write;
    o.reg_dst = if0.o_reg_dst;  o.mem_to_reg = if0.o_mem_to_reg;
    o.reg_write = if0.o_reg_write; o.src_a = if0.o_alu_src_a;
    o.src_b = if0.o_alu_src_b;  o.alu = if0.o_alu_control;
    o.pc_src = if0.o_pc_src;    o.ill = if0.o_illegal;
    return o;
  endfunction

  // Expected control word for one cycle spent in state st.
  function automatic obs_t exp_out(input int st, input logic [5:0] fn, input bit zf, input bit ill);
    obs_t e = '0;
    e.st  = 4'(st);
    e.alu = 4'b0010;
    e.ill = ill;
    case (st)
      0:  begin e.mem_read = 1; e.ir_write = 1; e.pc_write = 1; e.src_b = 2'b01; end
      1:  e.src_b = 2'b11;
      2:  begin e.src_a = 1; e.src_b = 2'b10; end
      3:  begin e.iord = 1; e.mem_read = 1; end
      4:  begin e.mem_to_reg = 1; e.reg_write = 1; end
      5:  begin e.iord = 1; e.mem_write = 1; end
      6:  begin e.src_a = 1; e.alu = funct_alu[funct_index(fn)]; end
      7:  begin e.reg_dst = 1; e.reg_write = 1; end
      8:  begin e.src_a = 1; e.alu = 4'b0110; e.pc_src = 2'b01; e.pc_write = zf; end
      9:  begin e.src_a = 1; e.src_b = 2'b10; end
      10: e.reg_write = 1;
      11: begin e.pc_src = 2'b10; e.pc_write = 1; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic chk(input string name, input obs_t got, input obs_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got state=%0d word=%h, expected state=%0d word=%h",
               name, got.st, got, exp.st, exp);
    end
  endtask

  // Run one instruction from its FETCH cycle. Entered and left at posedge+1.
  // stop_at >= 0 leaves the instruction at the start of that cycle, unpushed.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input bit zf_br, input int stop_at);
    bit ill = 1'b0;
    bit zf;
    path_q.delete();
    path_q.push_back(0);
    path_q.push_back(1);
    case (op)
      6'b100011: begin path_q.push_back(2); path_q.push_back(3); path_q.push_back(4); end
      6'b101011: begin path_q.push_back(2); path_q.push_back(5); end
      6'b000000: begin
        if (funct_index(fn) >= 0) begin path_q.push_back(6); path_q.push_back(7); end
        else ill = 1'b1;
      end
      6'b000100: path_q.push_back(8);
      6'b000010: path_q.push_back(11);
      6'b001000: begin path_q.push_back(9); path_q.push_back(10); end
      default:   ill = 1'b1;
    endcase
    for (int k = 0; k < path_q.size(); k++) begin
      if (k == stop_at) return;
      if (k <= 1) begin
        if0.i_opcode = op;
        if0.i_funct  = fn;
      end else begin
        if0.i_opcode = 6'($urandom);
        if0.i_funct  = 6'($urandom);
      end
      zf = (path_q[k] == 8) ? zf_br : 1'($urandom);
      if0.i_zf = zf;
      exp_q.push_back(exp_out(path_q[k], fn, zf, (k == 0) && prev_ill));
      @(posedge clk); #1;
    end
    prev_ill = ill;
  endtask

  // Asynchronous reset in the middle of a cycle, held across one edge.
  task automatic reset_mid(input string name);
    #1 rst_n = 1'b0;
    #1 chk({name, "_async"}, sample0(), exp_out(0, 6'd0, 1'b0, 1'b0));
    exp_q.delete();
    prev_ill = 1'b0;
    @(posedge clk); #1;
    chk({name, "_held"}, sample0(), exp_out(0, 6'd0, 1'b0, 1'b0));
    rst_n = 1'b1;
  endtask

  // Scoreboard monitor for the EN_ADDI=1 instance, plus a fixed-pattern
  // check of the EN_ADDI=0 instance, which is fed addi on every cycle.
  always @(negedge clk) begin
    if (rst_n && exp_q.size() > 0) chk("cycle", sample0(), exp_q.pop_front());
    if (!rst_n) begin
      cyc1 = 0;
    end else begin
      checks++;
      if (if1.o_state !== ((cyc1 % 2) ? 4'd1 : 4'd0) ||
          if1.o_illegal !== ((cyc1 % 2 == 0) && cyc1 > 0) ||
          if1.o_reg_write !== 1'b0) begin
        errors++;
        $display("FAIL noaddi: got state=%0d illegal=%0b reg_write=%0b at cycle %0d",
                 if1.o_state, if1.o_illegal, if1.o_reg_write, cyc1);
      end
      cyc1++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0] op, fn;
    if0.i_opcode = 6'd0; if0.i_funct = 6'd0; if0.i_zf = 1'b0;
    if1.i_opcode = 6'b001000; if1.i_funct = 6'd0; if1.i_zf = 1'b0;
    repeat (2) @(posedge clk);
    #2 chk("reset_state", sample0(), exp_out(0, 6'd0, 1'b0, 1'b0));
    rst_n = 1'b1;

    // Directed: lw, slt, bad funct, beq taken/not taken, sw, j, addi.
    run_instr(6'b100011, 6'h00, 1'b0, -1);
    run_instr(6'b000000, 6'h2a, 1'b0, -1);
    run_instr(6'b000000, 6'h01, 1'b0, -1);
    run_instr(6'b000100, 6'h00, 1'b1, -1);
    run_instr(6'b000100, 6'h00, 1'b0, -1);
    run_instr(6'b101011, 6'h00, 1'b0, -1);
    run_instr(6'b000010, 6'h00, 1'b0, -1);
    run_instr(6'b001000, 6'h00, 1'b0, -1);
    run_instr(6'b111111, 6'h00, 1'b0, -1);

    // Reset while the illegal pulse is up, then reset mid-store.
    chk("illegal_before_reset", sample0(), exp_out(0, 6'd0, 1'b0, 1'b1));
    exp_q.delete();
    reset_mid("reset_on_illegal");
    run_instr(6'b101011, 6'h00, 1'b0, 3);
    #1 chk("memwr_before_reset", sample0(), exp_out(5, 6'd0, 1'b0, 1'b0));
    reset_mid("reset_mid_memwr");

    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 7))
        0: op = 6'b100011;
        1: op = 6'b101011;
        2, 3: op = 6'b000000;
        4: op = 6'b000100;
        5: op = 6'b000010;
        6: op = 6'b001000;
        default: op = 6'($urandom);
      endcase
      fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : valid_funct[$urandom_range(0, 5)];
      run_instr(op, fn, 1'($urandom), -1);
    end

    @(negedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected cycles left unchecked, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 Parameter EN_ADDI, default 1: 1 = addi (opcode 001000) supported; 0 = addi treated as illegal.
REQ-002 i_clk  input  1  sole clock; all state changes on rising edge.
REQ-003 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 i_opcode  input  6  instruction bits [31:26] from instruction register.
REQ-005 i_funct  input  6  instruction bits [5:0] from instruction register.
REQ-006 i_zf  input  1  ALU zero flag, same cycle as o_alu_control.
REQ-007 o_pc_write  output  1  PC load enable.
REQ-008 o_iord  output  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-009 o_mem_read / o_mem_write / o_ir_write  output  1 each  memory read, memory write, IR load.
REQ-010 o_reg_dst / o_mem_to_reg / o_reg_write  output  1 each  rd(1)/rt(0) select, MDR(1)/ALUOut(0) select, register file write.
REQ-011 o_alu_src_a  output  1  0 = PC, 1 = register A.
REQ-012 o_alu_src_b  output  2  00 = register B, 01 = constant 4, 10 = sign-extended imm, 11 = imm<<2.
REQ-013 o_alu_control  output  4  ALU operation: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100.
REQ-014 o_pc_src  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-015 o_illegal  output  1  one-cycle pulse on unsupported opcode/funct.
REQ-016 o_state  output  4  current state encoding (debug).

Function
REQ-017 The block SHALL be a Moore FSM, 4-bit state: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, REX 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11; codes 12-15 SHALL go to FETCH next cycle, all outputs deasserted.
REQ-018 Outputs not listed for a state SHALL be 0, except o_alu_control SHALL default to ADD.
REQ-019 FETCH: mem_read, ir_write, pc_write =1; iord 0; src_a 0; src_b 01; ADD; pc_src 00; next DECODE.
REQ-020 DECODE: src_a 0, src_b 11, ADD; next by live i_opcode: 100011/101011 -> MEMADR, 000000 -> REX, 000100 -> BRANCH, 000010 -> JUMP, 001000 -> ADDIEX (if EN_ADDI), else FETCH with illegal.
REQ-021 R-type with i_funct not in {100000 add, 100010 sub, 100100 and, 100101 or, 100111 nor, 101010 slt} SHALL go DECODE -> FETCH with illegal, no writeback.
REQ-022 Opcode and funct SHALL be registered on DECODE exit; later states use registered copies only.
REQ-023 MEMADR: src_a 1, src_b 10, ADD; next MEMRD for lw, MEMWR for sw.
REQ-024 MEMRD: iord 1, mem_read 1; next MEMWB. MEMWB: reg_dst 0, mem_to_reg 1, reg_write 1; next FETCH.
REQ-025 MEMWR: iord 1, mem_write 1; next FETCH.
REQ-026 REX: src_a 1, src_b 00, alu_control decoded from registered funct (add->0010, sub->0110, and->0000, or->0001, nor->1100, slt->0111); next ALUWB.
REQ-027 ALUWB: reg_dst 1, mem_to_reg 0, reg_write 1; next FETCH.
REQ-028 BRANCH: src_a 1, src_b 00, SUB, pc_src 01; o_pc_write SHALL equal i_zf combinationally (only combinational input-to-output path); next FETCH.
REQ-029 ADDIEX: src_a 1, src_b 10, ADD; next ADDIWB. ADDIWB: reg_dst 0, mem_to_reg 0, reg_write 1; next FETCH.
REQ-030 JUMP: pc_src 10, pc_write 1; next FETCH.
REQ-031 Cycles per instruction incl. FETCH: lw 5; sw, R-type, addi 4; beq, j 3; illegal 2.
REQ-032 o_illegal SHALL be registered, high exactly the cycle after the DECODE that detected it (coincident with next FETCH).
REQ-033 o_mem_write and o_reg_write SHALL never both be 1; o_mem_read and o_mem_write SHALL never both be 1.

Reset
REQ-034 i_rst_n low SHALL immediately force state FETCH, o_illegal 0, registered opcode/funct 0, regardless of clock.
REQ-035 Reset mid-instruction SHALL abort it; no partial write occurs after assertion; first edge after release executes FETCH.
REQ-036 During reset, outputs SHALL equal FETCH decode (pc_write 1 gated by external reset of PC).

Verification
REQ-037 Reset release, opcode 100011 -> states 0,1,2,3,4,0; reg_write+mem_to_reg only in state 4; 5 cycles.
REQ-038 R-type funct 101010 -> state 6 drives alu_control 0111, state 7 reg_write=1 reg_dst=1; funct 000001 -> 0,1,0 with o_illegal pulse, no reg_write.
REQ-039 beq with i_zf=1 in BRANCH -> pc_write=1 pc_src=01; repeat i_zf=0 -> pc_write=0; both 3 cycles.
REQ-040 sw -> states 0,1,2,5,0; mem_write=1 iord=1 only in 5; EN_ADDI=0 with opcode 001000 -> illegal pulse.
REQ-041 i_rst_n low asynchronously mid-MEMWR -> mem_write drops before next edge, o_state 0.
REQ-042 j (000010) -> states 0,1,11,0 with pc_src=10 pc_write=1 in 11; opcode changing after DECODE does not alter path.
